// File: rtl/impulse_pkg.sv
// Shared types and constants for the envelope/oscillator datapath.
package impulse_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } env_state_t;

   localparam logic [14:0] ENV_MAX = 15'd32767;

endpackage

// File: rtl/adsr_envelope_tick_gen.sv
// Prescaler: one-cycle tick every DIV clocks, counter restarts from 0 on rst.
module tick_gen #(
   parameter int unsigned DIV = 1024
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(DIV - 1);

   logic [15:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst)
         count_reg <= '0;
      else if (count_reg == LAST)
         count_reg <= '0;
      else
         count_reg <= count_reg + 16'd1;
   end

   assign tick = (count_reg == LAST);

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: gate-driven FSM stepping a 15-bit level on prescaled ticks.
module adsr_envelope
   import impulse_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               gate,
   input  logic [15:0]        attack_rate,
   input  logic [15:0]        decay_rate,
   input  logic [14:0]        sustain_level,
   input  logic [15:0]        release_rate,
   output logic signed [16:0] volume,
   output logic [2:0]         state,
   output logic               active
);

   env_state_t  state_reg, state_next;
   logic [14:0] level_reg, level_next;
   logic        tick;

   logic [16:0] attack_sum;
   logic [16:0] decay_diff;
   logic [16:0] decay_floor;
   logic [16:0] release_diff;

   tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // 17-bit arithmetic so neither overflow past ENV_MAX nor underflow below 0 wraps.
   assign attack_sum   = {2'b00, level_reg} + {1'b0, attack_rate};
   assign decay_diff   = {2'b00, level_reg} - {1'b0, decay_rate};
   assign decay_floor  = {2'b00, sustain_level} + {1'b0, decay_rate};
   assign release_diff = {2'b00, level_reg} - {1'b0, release_rate};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         level_reg <= '0;
      end else begin
         state_reg <= state_next;
         level_reg <= level_next;
      end
   end

   // Gate checks come before tick so a coincident gate change never steps the level.
   always_comb begin
      state_next = state_reg;
      level_next = level_reg;
      case (state_reg)
         IDLE: begin
            level_next = '0;
            if (gate)
               state_next = ATTACK;
         end
         ATTACK: begin
            if (!gate) begin
               state_next = RELEASE;
            end else if (tick) begin
               if (attack_rate == 16'd0 || attack_sum >= {2'b00, ENV_MAX}) begin
                  level_next = ENV_MAX;
                  state_next = DECAY;
               end else begin
                  level_next = attack_sum[14:0];
               end
            end
         end
         DECAY: begin
            if (!gate) begin
               state_next = RELEASE;
            end else if (tick) begin
               if (decay_rate == 16'd0 || {2'b00, level_reg} <= decay_floor) begin
                  level_next = sustain_level;
                  state_next = SUSTAIN;
               end else begin
                  level_next = decay_diff[14:0];
               end
            end
         end
         SUSTAIN: begin
            if (!gate)
               state_next = RELEASE;
            else if (tick)
               level_next = sustain_level;
         end
         RELEASE: begin
            if (gate) begin
               state_next = ATTACK;
            end else if (tick) begin
               if (release_rate == 16'd0 || {1'b0, level_reg} <= release_rate) begin
                  level_next = '0;
                  state_next = IDLE;
               end else begin
                  level_next = release_diff[14:0];
               end
            end
         end
         default: begin
            state_next = IDLE;
            level_next = '0;
         end
      endcase
   end

   assign volume = {2'b00, level_reg};
   assign state  = state_reg;
   assign active = (state_reg != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: TICK_DIV=4 instance for the main sequence, TICK_DIV=1 for zero rates.
module tb_adsr_envelope;
   import impulse_pkg::*;

   typedef struct {
      string       tag;
      bit          sel;
      logic [16:0] vol;
      logic [2:0]  st;
      logic        act;
   } exp_t;

   logic clk;

   logic               rst_a, gate_a;
   logic [15:0]        atk_a, dec_a, rel_a;
   logic [14:0]        sus_a;
   logic signed [16:0] vol_a;
   logic [2:0]         st_a;
   logic               act_a;

   logic               rst_b, gate_b;
   logic [15:0]        atk_b, dec_b, rel_b;
   logic [14:0]        sus_b;
   logic signed [16:0] vol_b;
   logic [2:0]         st_b;
   logic               act_b;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   adsr_envelope #(.TICK_DIV(4)) dut_a (
      .clk(clk), .rst(rst_a), .gate(gate_a),
      .attack_rate(atk_a), .decay_rate(dec_a), .sustain_level(sus_a), .release_rate(rel_a),
      .volume(vol_a), .state(st_a), .active(act_a)
   );

   adsr_envelope #(.TICK_DIV(1)) dut_b (
      .clk(clk), .rst(rst_b), .gate(gate_b),
      .attack_rate(atk_b), .decay_rate(dec_b), .sustain_level(sus_b), .release_rate(rel_b),
      .volume(vol_b), .state(st_b), .active(act_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Push the expectation, advance n edges, then pop and compare.
   task automatic expect_after(input bit sel, input int n, input string tag,
                               input int vol, input env_state_t st);
      exp_t e, got;
      logic [16:0] ov;
      logic [2:0]  os;
      logic        oa;
      e.tag = tag;
      e.sel = sel;
      e.vol = 17'(vol);
      e.st  = st;
      e.act = (st != IDLE);
      sb.push_back(e);
      step(n);
      got = sb.pop_front();
      ov = got.sel ? vol_b : vol_a;
      os = got.sel ? st_b  : st_a;
      oa = got.sel ? act_b : act_a;
      $display("txn %s dut_%s vol=%0d state=%0d active=%0d", got.tag,
               got.sel ? "b" : "a", ov, os, oa);
      checks++;
      assert (ov === got.vol) else begin
         errors++;
         $error("FAIL %s volume observed %0d expected %0d", got.tag, ov, got.vol);
      end
      checks++;
      assert (os === got.st) else begin
         errors++;
         $error("FAIL %s state observed %0d expected %0d", got.tag, os, got.st);
      end
      checks++;
      assert (oa === got.act) else begin
         errors++;
         $error("FAIL %s active observed %0d expected %0d", got.tag, oa, got.act);
      end
   endtask

   initial begin
      rst_a = 1'b1; gate_a = 1'b0; atk_a = '0; dec_a = '0; sus_a = '0; rel_a = '0;
      rst_b = 1'b1; gate_b = 1'b0; atk_b = '0; dec_b = '0; sus_b = 15'd100; rel_b = '0;

      // Gate held high during reset must be ignored.
      gate_a = 1'b1;
      expect_after(0, 2, "a_reset", 0, IDLE);
      rst_a = 1'b0; atk_a = 16'd10000;
      expect_after(0, 1, "a_gate_on", 0, ATTACK);
      expect_after(0, 3, "a_atk1", 10000, ATTACK);
      expect_after(0, 4, "a_atk2", 20000, ATTACK);
      expect_after(0, 4, "a_atk3", 30000, ATTACK);
      expect_after(0, 4, "a_atk_sat", 32767, DECAY);

      dec_a = 16'd5000; sus_a = 15'd20000;
      expect_after(0, 4, "a_dec1", 27767, DECAY);
      dec_a = 16'd30000;
      step(1);
      dec_a = 16'd5000;
      expect_after(0, 3, "a_dec2_rate_glitch", 22767, DECAY);
      expect_after(0, 4, "a_dec_sus", 20000, SUSTAIN);
      sus_a = 15'd15000;
      expect_after(0, 4, "a_sus_track", 15000, SUSTAIN);

      gate_a = 1'b0; rel_a = 16'd6000;
      expect_after(0, 1, "a_rel_enter", 15000, RELEASE);
      expect_after(0, 3, "a_rel1", 9000, RELEASE);
      expect_after(0, 4, "a_rel2", 3000, RELEASE);
      expect_after(0, 4, "a_rel_idle", 0, IDLE);

      gate_a = 1'b1; atk_a = 16'd9000;
      expect_after(0, 1, "a_gate_on2", 0, ATTACK);
      expect_after(0, 3, "a_atk_9000", 9000, ATTACK);
      gate_a = 1'b0;
      expect_after(0, 1, "a_rel_9000", 9000, RELEASE);
      gate_a = 1'b1; atk_a = 16'd5000;
      expect_after(0, 1, "a_retrigger", 9000, ATTACK);
      expect_after(0, 2, "a_retrig_atk", 14000, ATTACK);

      step(3);
      gate_a = 1'b0; rel_a = 16'd1000;
      expect_after(0, 1, "a_gate_on_tick", 14000, RELEASE);
      expect_after(0, 4, "a_rel_1000", 13000, RELEASE);

      gate_a = 1'b1; atk_a = 16'd7000;
      expect_after(0, 1, "a_retrig2", 13000, ATTACK);
      expect_after(0, 3, "a_atk_20000", 20000, ATTACK);
      rst_a = 1'b1;
      expect_after(0, 1, "a_mid_reset", 0, IDLE);
      rst_a = 1'b0;
      expect_after(0, 1, "a_post_rst_gate", 0, ATTACK);
      expect_after(0, 2, "a_no_early_tick", 0, ATTACK);
      expect_after(0, 1, "a_first_tick", 7000, ATTACK);

      atk_a = 16'd30000;
      expect_after(0, 4, "a_atk_sat2", 32767, DECAY);
      sus_a = 15'd32767; dec_a = 16'd5000;
      expect_after(0, 4, "a_sus_max", 32767, SUSTAIN);

      expect_after(1, 0, "b_reset", 0, IDLE);
      rst_b = 1'b0; gate_b = 1'b1;
      expect_after(1, 1, "b_gate_on", 0, ATTACK);
      expect_after(1, 1, "b_atk_instant", 32767, DECAY);
      expect_after(1, 1, "b_dec_instant", 100, SUSTAIN);
      gate_b = 1'b0;
      expect_after(1, 1, "b_rel_enter", 100, RELEASE);
      expect_after(1, 1, "b_rel_instant", 0, IDLE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
